piece_queue: RTL
================

PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter DEPTH, default 3, meaning number of queued block codes (2..8).
REQ-002 Parameter GEN_LAT, default 1, meaning cycles from gen_req_o pulse to a valid gen_code_i (1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 flush_i  input  1  synchronous clear of queue contents and any outstanding request.
REQ-006 gen_req_o  output  1  one-cycle pulse asking the block generator (counter) to produce and advance.
REQ-007 gen_code_i  input  3  block_t code from the generator; sampled GEN_LAT cycles after gen_req_o.
REQ-008 piece_valid_o  output  1  head entry present.
REQ-009 piece_ready_i  input  1  game FSM accepts head entry.
REQ-010 piece_o  output  3  head block_t code (BLOCK_L=0 ... BLOCK_STEPS=6).
REQ-011 preview_valid_o  output  1  second entry present.
REQ-012 preview_o  output  3  second block_t code (next-piece display).
REQ-013 count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 bad_code_o  output  1  one-cycle pulse when a sampled code equals 7.

Function
REQ-015 Storage: circular buffer of DEPTH x 3-bit entries; rd/wr pointers wrap DEPTH-1 -> 0.
REQ-016 Fill FSM states: IDLE, REQ, WAIT.
REQ-017 IDLE -> REQ when count_o < DEPTH and flush_i = 0; otherwise stay.
REQ-018 REQ: gen_req_o = 1 for exactly this cycle; next state WAIT with latency counter loaded to GEN_LAT.
REQ-019 WAIT: counter decrements each cycle; on the cycle it reaches 0, gen_code_i is sampled and state -> IDLE.
REQ-020 At most one request outstanding; gen_req_o never asserted in WAIT or in consecutive cycles.
REQ-021 Sampled code 0..6: pushed at wr pointer, count +1; code 7: not pushed, bad_code_o pulses 1 cycle, IDLE re-requests normally.
REQ-022 Push never overflows: requests issue only when count < DEPTH and count only decreases while outstanding.
REQ-023 Pop: piece_valid_o & piece_ready_i advances rd pointer, count -1; piece_ready_i with piece_valid_o = 0 ignored.
REQ-024 Simultaneous push and pop: both performed, count unchanged; a push into an empty queue is visible on piece_o the following cycle (no bypass).
REQ-025 piece_valid_o = (count >= 1); preview_valid_o = (count >= 2); piece_o/preview_o are entries at rd and rd+1 (mod DEPTH); values undefined-but-stable when not valid are not allowed -- drive 0.
REQ-026 flush_i: next cycle count = 0, pointers = 0, FSM = IDLE, latency counter cleared; a code arriving for an aborted request is discarded; flush has priority over push and pop in the same cycle.
REQ-027 All outputs except piece_o/preview_o (registered-entry muxes) come from registers; no combinational path from piece_ready_i to any output.

Reset
REQ-028 rst_i sampled on rising edge; same effect as flush_i and overrides all inputs.
REQ-029 Reset values: gen_req_o = 0, piece_valid_o = 0, preview_valid_o = 0, piece_o = 0, preview_o = 0, count_o = 0, bad_code_o = 0, FSM = IDLE.
REQ-030 Reset mid-WAIT: outstanding request abandoned; first gen_req_o after release occurs 1 cycle after rst_i deasserts.

Verification
REQ-031 Cold fill, GEN_LAT=1, generator returns 1,2,3, piece_ready_i=0 -> three gen_req_o pulses each 3 cycles apart, count_o 1,2,3, piece_o=1, preview_o=2, no 4th request.
REQ-032 Full queue (1,2,3), piece_ready_i=1 one cycle -> piece_o=2, preview_o=3, count_o=2, gen_req_o pulse next cycle, returned 4 lands in tail, count_o=3.
REQ-033 Push and pop same cycle at count_o=1 -> count_o stays 1, piece_o becomes the pushed code next cycle.
REQ-034 Generator returns 7 -> bad_code_o pulses once, count_o unchanged, new gen_req_o follows, valid code then pushed.
REQ-035 flush_i asserted in WAIT with count_o=2 -> count_o=0, piece_valid_o=0 next cycle, late code not pushed, fresh request follows.
REQ-036 Pointer wrap: pop/push 7 pieces 0..6 through DEPTH=3 -> piece_o presents 0,1,...,6 in order with no loss or duplicate.

Source files
------------

// File: rtl/piece_queue.sv
// Piece queue: a small circular buffer of upcoming block codes, kept topped up by a
// request/wait fill FSM that talks to an external block generator with fixed latency.
module piece_queue #(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned GEN_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       flush_i,
    output logic                       gen_req_o,
    input  logic [2:0]                 gen_code_i,
    output logic                       piece_valid_o,
    input  logic                       piece_ready_i,
    output logic [2:0]                 piece_o,
    output logic                       preview_valid_o,
    output logic [2:0]                 preview_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       bad_code_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(GEN_LAT + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_LOAD = LW'(GEN_LAT);

    typedef enum logic [1:0] {StIdle, StReq, StWait} fill_state_e;

    fill_state_e   state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
    logic          gen_req_q, gen_req_d;
    logic          bad_q, bad_d;
    logic          piece_valid_q, piece_valid_d;
    logic          preview_valid_q, preview_valid_d;
    logic          sample, push, pop;
    logic [2:0]    mem_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        sample  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && count_q < FULL_CNT) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
                lat_d   = LAT_LOAD;
            end
            StWait: begin
                lat_d = lat_q - LW'(1);
                // Counter hits zero this cycle: the generator's code is valid now.
                if (lat_q <= LW'(1)) begin
                    sample  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        push  = sample && (gen_code_i != 3'd7);
        bad_d = sample && (gen_code_i == 3'd7);
        pop   = piece_valid_q && piece_ready_i;

        rd_d    = pop ? ptr_inc(rd_q) : rd_q;
        wr_d    = push ? ptr_inc(wr_q) : wr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        // Flush wins over everything, including a code arriving for the aborted request.
        if (flush_i) begin
            state_d = StIdle;
            lat_d   = '0;
            push    = 1'b0;
            bad_d   = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end

        gen_req_d       = (state_d == StReq);
        piece_valid_d   = (count_d != '0);
        preview_valid_d = (count_d >= CW'(2));
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q         <= StIdle;
            lat_q           <= '0;
            count_q         <= '0;
            rd_q            <= '0;
            wr_q            <= '0;
            gen_req_q       <= 1'b0;
            bad_q           <= 1'b0;
            piece_valid_q   <= 1'b0;
            preview_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lat_q           <= lat_d;
            count_q         <= count_d;
            rd_q            <= rd_d;
            wr_q            <= wr_d;
            gen_req_q       <= gen_req_d;
            bad_q           <= bad_d;
            piece_valid_q   <= piece_valid_d;
            preview_valid_q <= preview_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst_i) begin
            mem_q[wr_q] <= gen_code_i;
        end
    end

    assign rd_nxt          = ptr_inc(rd_q);
    assign gen_req_o       = gen_req_q;
    assign bad_code_o      = bad_q;
    assign count_o         = count_q;
    assign piece_valid_o   = piece_valid_q;
    assign preview_valid_o = preview_valid_q;
    assign piece_o         = piece_valid_q ? mem_q[rd_q] : 3'd0;
    assign preview_o       = preview_valid_q ? mem_q[rd_nxt] : 3'd0;

endmodule
